// File: rtl/kbd_scan_fsm_if.sv
// rtl/kbd_scan_fsm_if.sv - PS/2 receiver FIFO pop handshake bundle
//
// Purpose: carries the head-of-FIFO byte, its ready/overflow flags and the
//          active-low pop strobe between a PS/2 receiver and its consumer.
// Signals:
//   ps2_data   [7:0]  byte at the head of the receiver FIFO
//   ps2_ready         high while the receiver FIFO is non-empty
//   overflow          receiver FIFO overflow flag
//   nextdata_n        active-low pop strobe from the consumer
// Modports:
//   master  receiver side (drives data/flags, samples the pop strobe)
//   slave   consumer side (kbd_scan_fsm)
interface kbd_scan_fsm_if;
   logic [7:0] ps2_data;
   logic       ps2_ready;
   logic       overflow;
   logic       nextdata_n;

   modport master (output ps2_data, output ps2_ready, output overflow, input nextdata_n);
   modport slave  (input ps2_data, input ps2_ready, input overflow, output nextdata_n);
endinterface

// File: rtl/kbd_scan_fsm.sv
// rtl/kbd_scan_fsm.sv - PS/2 scan-code set 2 make/break decoder with press counter
//
// Purpose: pops bytes from a PS/2 receiver FIFO, tracks E0/F0 prefixes and
//          reports the currently held key, a press counter and a sticky error.
// Ports:
//   clk          system clock, rising edge
//   clrn         asynchronous active-low reset
//   rx           receiver handshake (slave modport of kbd_scan_fsm_if)
//   scan_code    make code of the current or last key
//   key_valid    high while that key is held
//   key_ext      current key was E0-prefixed
//   press_count  count of distinct presses, wraps modulo 2^CNT_W
//   new_press    one-cycle pulse per counted press
//   err          sticky protocol / overflow error
module kbd_scan_fsm #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clrn,
   kbd_scan_fsm_if.slave    rx,
   output logic [7:0]       scan_code,
   output logic             key_valid,
   output logic             key_ext,
   output logic [CNT_W-1:0] press_count,
   output logic             new_press,
   output logic             err
);

   typedef enum logic [1:0] {
      S_MAKE      = 2'd0,
      S_EXT       = 2'd1,
      S_BREAK     = 2'd2,
      S_EXT_BREAK = 2'd3
   } state_t;

   localparam logic [7:0] B_EXT   = 8'hE0;
   localparam logic [7:0] B_BREAK = 8'hF0;

   state_t             state_q, state_d;
   logic [7:0]         scan_q, scan_d;
   logic               valid_q, valid_d;
   logic               ext_q, ext_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               np_q, np_d;
   logic               err_q, err_d;
   logic               pop_ok_q;   // nextdata_n was high in the previous cycle

   logic               accept;
   logic [7:0]         b;
   logic               bad_byte;

   // clrn gates the strobe so no pop is issued while reset is held, even
   // though pop_ok_q resets high to allow an accept right after release.
   assign accept        = clrn & rx.ps2_ready & pop_ok_q;
   assign rx.nextdata_n = ~accept;
   assign b             = rx.ps2_data;
   assign bad_byte      = (b == 8'h00) || (b == 8'hFF);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= S_MAKE;
         scan_q   <= 8'h00;
         valid_q  <= 1'b0;
         ext_q    <= 1'b0;
         cnt_q    <= '0;
         np_q     <= 1'b0;
         err_q    <= 1'b0;
         pop_ok_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         scan_q   <= scan_d;
         valid_q  <= valid_d;
         ext_q    <= ext_d;
         cnt_q    <= cnt_d;
         np_q     <= np_d;
         err_q    <= err_d;
         pop_ok_q <= rx.nextdata_n;
      end
   end

   always_comb begin
      state_d = state_q;
      scan_d  = scan_q;
      valid_d = valid_q;
      ext_d   = ext_q;
      cnt_d   = cnt_q;
      np_d    = 1'b0;
      // Overflow and a same-cycle accept both take effect.
      err_d   = err_q | rx.overflow;

      if (accept) begin
         if (bad_byte) begin
            err_d   = 1'b1;
            state_d = S_MAKE;
         end else begin
            unique case (state_q)
               S_MAKE, S_EXT: begin
                  if (b == B_EXT) begin
                     state_d = S_EXT;
                  end else if (b == B_BREAK) begin
                     state_d = (state_q == S_EXT) ? S_EXT_BREAK : S_BREAK;
                  end else begin
                     state_d = S_MAKE;
                     // A make identical to the held key is typematic repeat.
                     if (!(valid_q && (scan_q == b) && (ext_q == (state_q == S_EXT)))) begin
                        scan_d  = b;
                        ext_d   = (state_q == S_EXT);
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        np_d    = 1'b1;
                     end
                  end
               end
               S_BREAK, S_EXT_BREAK: begin
                  state_d = S_MAKE;
                  if ((b == B_EXT) || (b == B_BREAK)) begin
                     err_d = 1'b1;
                  end else if (valid_q && (b == scan_q) &&
                               (ext_q == (state_q == S_EXT_BREAK))) begin
                     valid_d = 1'b0;
                  end
               end
               default: state_d = S_MAKE;
            endcase
         end
      end
   end

   assign scan_code   = scan_q;
   assign key_valid   = valid_q;
   assign key_ext     = ext_q;
   assign press_count = cnt_q;
   assign new_press   = np_q;
   assign err         = err_q;

endmodule
